// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and frame checking for the keyboard receive path.
// Also used by the scan-code decoder, which is why the scan-code constants live here.
package ps2_pkg;

    localparam int FRAME_LEN = 11;
    localparam int BIT_START = 0;
    localparam int BIT_PAR   = 9;
    localparam int BIT_STOP  = 10;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        FRM_OK,
        FRM_BAD_START,
        FRM_BAD_STOP,
        FRM_BAD_PAR
    } frame_chk_e;

    // Parity covers the data bits and the parity bit itself and must be odd.
    function automatic frame_chk_e check_frame(input logic [FRAME_LEN-1:0] f);
        if (f[BIT_START] != 1'b0) begin
            return FRM_BAD_START;
        end
        if (f[BIT_STOP] != 1'b1) begin
            return FRM_BAD_STOP;
        end
        if ((^f[BIT_PAR:1]) != 1'b1) begin
            return FRM_BAD_PAR;
        end
        return FRM_OK;
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Single-clock FIFO for received scan codes; one slot is kept empty to tell full from empty.
// Writes into a full FIFO and reads from an empty one are ignored.
module ps2_sync_fifo #(
    parameter int AW = 3,
    parameter int W  = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         push_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         pop_i,
    output logic [W-1:0] rd_data_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] w_ptr_q, w_ptr_d;
    logic [AW-1:0] r_ptr_q, r_ptr_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o   = (w_ptr_q == r_ptr_q);
    assign full_o    = ((w_ptr_q + 1'b1) == r_ptr_q);
    assign rd_data_o = mem_q[r_ptr_q];

    // Full/empty are evaluated on the pre-update pointers, so a push into
    // a full FIFO is dropped even if a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (do_push) begin
            w_ptr_d = w_ptr_q + 1'b1;
        end
        if (do_pop) begin
            r_ptr_d = r_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[w_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: synchronises the pins, deframes 11-bit frames
// and queues good scan-code bytes for the decoder behind a ready/pop handshake.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       ready,
    input  logic       nextdata_n,
    output logic [2:0] ps2_clk_sync,
    output logic       sample,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]           ps2_clk_sync_q;
    logic [1:0]           data_sync_q;
    logic [3:0]           count_q, count_d;
    logic [BIT_PAR:0]     buf_q, buf_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 overflow_q, overflow_d;
    logic [FRAME_LEN-1:0] frame_w;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;

    assign sample       = ps2_clk_sync_q[2] & ~ps2_clk_sync_q[1];
    assign ps2_clk_sync = ps2_clk_sync_q;
    assign overflow     = overflow_q;
    assign ready        = ~fifo_empty;
    assign pop          = ready & ~nextdata_n;

    // The stop bit is taken straight from the synchroniser so the frame can
    // be judged in the same cycle its last bit is sampled.
    assign frame_w = {data_sync_q[1], buf_q};

    always_ff @(posedge clk) begin
        if (clr) begin
            ps2_clk_sync_q <= 3'b111;
            data_sync_q    <= 2'b11;
        end else begin
            ps2_clk_sync_q <= {ps2_clk_sync_q[1:0], ps2_clk};
            data_sync_q    <= {data_sync_q[0], ps2_data};
        end
    end

    always_comb begin
        count_d    = count_q;
        buf_d      = buf_q;
        timer_d    = timer_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        if (sample) begin
            timer_d = TW'(TIMEOUT_CYC - 1);
            if (count_q == 4'(BIT_STOP)) begin
                count_d = '0;
                if (check_frame(frame_w) == FRM_OK) begin
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end else begin
                buf_d[count_q] = data_sync_q[1];
                count_d        = count_q + 4'd1;
            end
        end else if (count_q != '0) begin
            // A stalled partial frame is dropped so the next start bit realigns.
            if (timer_q == '0) begin
                count_d = '0;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q    <= '0;
            buf_q      <= '0;
            timer_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            buf_q      <= buf_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_sync_fifo #(
        .AW (FIFO_AW),
        .W  (8)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push_i    (push),
        .wr_data_i (frame_w[8:1]),
        .pop_i     (pop),
        .rd_data_o (data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus randomized
// frames checked against a queue model of the receive FIFO.
module tb_ps2_keyboard;
    import ps2_pkg::*;

    localparam int HP  = 8;
    localparam int TO  = 300;
    localparam int CAP = 7;

    logic       clk = 1'b0;
    logic       clr;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic [2:0] ps2_clk_sync;
    logic       sample;
    logic       overflow;

    int         pass_cnt = 0;
    int         total    = 0;
    logic [7:0] mq[$];
    logic       movf;

    ps2_keyboard #(.FIFO_AW(3), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .clr          (clr),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .data         (data),
        .ready        (ready),
        .nextdata_n   (nextdata_n),
        .ps2_clk_sync (ps2_clk_sync),
        .sample       (sample),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_bit(input logic b);
        ps2_data = b;
        tick(HP);
        ps2_clk = 1'b0;
        tick(HP);
        ps2_clk = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start, otherwise good
    function automatic logic [10:0] mkframe(input logic [7:0] b, input int kind);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        case (kind)
            1: f[9]  = ~f[9];
            2: f[10] = 1'b0;
            3: f[0]  = 1'b1;
            default: ;
        endcase
        return f;
    endfunction

    function automatic bit accept(input logic [10:0] f);
        int ones;
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(f[i]);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && ((ones % 2) == 1);
    endfunction

    task automatic send_frame(input logic [10:0] f);
        for (int i = 0; i < 11; i++) do_bit(f[i]);
        tick(HP);
        if (accept(f)) begin
            if (mq.size() >= CAP) movf = 1'b1;
            else mq.push_back(f[8:1]);
        end
    endtask

    task automatic pop_one();
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
        mq.delete();
        movf = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        mq.delete(); movf = 1'b0;
        tick(3);
        clr = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else pass_cnt++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else pass_cnt++;
        total++; if (ps2_clk_sync !== 3'b111) $display("FAIL reset_sync got %b exp 111", ps2_clk_sync); else pass_cnt++;
        total++; if (sample !== 1'b0) $display("FAIL reset_sample got %b exp 0", sample); else pass_cnt++;
    endtask

    task automatic test_single();
        logic [10:0] f;
        bit found;
        do_reset();
        f = mkframe(8'h1C, 0);
        total++; if (f !== 11'b10000111000) $display("FAIL single_frame_bits got %b exp 10000111000", f); else pass_cnt++;
        for (int i = 0; i < 10; i++) do_bit(f[i]);
        ps2_data = f[10];
        tick(HP);
        ps2_clk = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (sample === 1'b1) found = 1'b1;
        end
        total++; if (!found) $display("FAIL single_sample got 0 exp 1"); else pass_cnt++;
        total++; if (ready !== 1'b0) $display("FAIL single_ready_early got %b exp 0", ready); else pass_cnt++;
        @(negedge clk);
        total++; if (ready !== 1'b1) $display("FAIL single_ready got %b exp 1", ready); else pass_cnt++;
        total++; if (data !== 8'h1C) $display("FAIL single_data got %h exp 1c", data); else pass_cnt++;
        total++; if (overflow !== 1'b0) $display("FAIL single_overflow got %b exp 0", overflow); else pass_cnt++;
        tick(HP);
        ps2_clk = 1'b1;
        tick(HP);
    endtask

    task automatic test_two_pops();
        do_reset();
        send_frame(mkframe(SC_BREAK, 0));
        send_frame(mkframe(8'h1C, 0));
        total++; if (data !== 8'hF0) $display("FAIL two_first got %h exp f0", data); else pass_cnt++;
        pop_one();
        total++; if (data !== 8'h1C || ready !== 1'b1) $display("FAIL two_second got %h/%b exp 1c/1", data, ready); else pass_cnt++;
        pop_one();
        total++; if (ready !== 1'b0) $display("FAIL two_empty got %b exp 0", ready); else pass_cnt++;
    endtask

    task automatic test_bad_frames();
        do_reset();
        send_frame(mkframe(8'h1C, 1));
        send_frame(mkframe(8'h1C, 2));
        total++; if (ready !== 1'b0) $display("FAIL bad_ready got %b exp 0", ready); else pass_cnt++;
        send_frame(mkframe(8'h32, 0));
        total++; if (data !== 8'h32 || ready !== 1'b1) $display("FAIL bad_then_good got %h/%b exp 32/1", data, ready); else pass_cnt++;
        total++; if (overflow !== 1'b0) $display("FAIL bad_overflow got %b exp 0", overflow); else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) send_frame(mkframe(8'($urandom), 0));
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else pass_cnt++;
        for (int i = 0; i < CAP; i++) begin
            total++;
            if (ready !== 1'b1 || data !== mq[0]) $display("FAIL ovf_pop%0d got %h/%b exp %h/1", i, data, ready, mq[0]);
            else pass_cnt++;
            pop_one();
        end
        total++; if (ready !== 1'b0) $display("FAIL ovf_drained got %b exp 0", ready); else pass_cnt++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [10:0] junk;
        do_reset();
        junk = mkframe(8'($urandom), 0);
        for (int i = 0; i < 5; i++) do_bit(junk[i]);
        tick(TO + 50);
        send_frame(mkframe(8'h1C, 0));
        total++; if (data !== 8'h1C || ready !== 1'b1) $display("FAIL timeout_data got %h/%b exp 1c/1", data, ready); else pass_cnt++;
        pop_one();
        total++; if (ready !== 1'b0) $display("FAIL timeout_single got %b exp 0", ready); else pass_cnt++;
        for (int i = 0; i < 5; i++) do_bit(junk[i]);
        do_reset();
        send_frame(mkframe(8'h1C, 0));
        total++; if (data !== 8'h1C || ready !== 1'b1) $display("FAIL clrmid_data got %h/%b exp 1c/1", data, ready); else pass_cnt++;
        pop_one();
        total++; if (ready !== 1'b0) $display("FAIL clrmid_single got %b exp 0", ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        do_reset();
        send_frame(mkframe(SC_EXT, 0));
        for (int i = 0; i < 2; i++) send_frame(mkframe(8'($urandom), 0));
        for (int i = 0; i < 3; i++) exp_b[i] = mq[i];
        @(negedge clk);
        nextdata_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ready !== 1'b1 || data !== exp_b[i]) $display("FAIL b2b_%0d got %h/%b exp %h/1", i, data, ready, exp_b[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        total++; if (ready !== 1'b0) $display("FAIL b2b_empty got %b exp 0", ready); else pass_cnt++;
        tick(2);
        nextdata_n = 1'b1;
        mq.delete();
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 20; it++) begin
            send_frame(mkframe(8'($urandom), int'($urandom_range(0, 5))));
            total++; if (overflow !== movf) $display("FAIL rnd_ovf%0d got %b exp %b", it, overflow, movf); else pass_cnt++;
            if ($urandom_range(0, 2) == 0) begin
                total++;
                if (ready !== (mq.size() != 0)) $display("FAIL rnd_ready%0d got %b exp %b", it, ready, mq.size() != 0);
                else pass_cnt++;
                if (mq.size() != 0) begin
                    total++; if (data !== mq[0]) $display("FAIL rnd_data%0d got %h exp %h", it, data, mq[0]); else pass_cnt++;
                end
                pop_one();
            end
        end
    endtask

    task automatic test_clear_queued();
        if (mq.size() == 0) send_frame(mkframe(8'h55, 0));
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mq.delete();
        movf = 1'b0;
        total++; if (ready !== 1'b0) $display("FAIL clr_ready got %b exp 0", ready); else pass_cnt++;
        total++; if (overflow !== 1'b0) $display("FAIL clr_overflow got %b exp 0", overflow); else pass_cnt++;
        total++; if (ps2_clk_sync !== 3'b111) $display("FAIL clr_sync got %b exp 111", ps2_clk_sync); else pass_cnt++;
        send_frame(mkframe(8'hA7, 0));
        total++; if (data !== 8'hA7 || ready !== 1'b1) $display("FAIL clr_newframe got %h/%b exp a7/1", data, ready); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_pops();
        test_bad_frames();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_random();
        test_clear_queued();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
